// File: rtl/prog_packet_rx.sv
// Byte-stream program packet receiver: SYNC, command, little-endian payload, XOR checksum.
// Define PROG_RX_FRAME_SYNC_EN to hold accepted commits until the next frame_start pulse.
module prog_packet_rx #(
  parameter int unsigned PROG_PAYLD_PKT_BITS = 48,
  parameter logic [7:0]  SYNC_BYTE           = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES      = 100000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  input  logic                           frame_start,
  output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
  output logic                           is_sym_mode,
  output logic                           pkt_ok,
  output logic                           pkt_err
);

  localparam int unsigned NBYTES = PROG_PAYLD_PKT_BITS / 8;
  localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CMD_NOP   = 8'h00;
  localparam logic [7:0]    CMD_LOAD  = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  state_e                         state_q, state_d;
  logic [PROG_PAYLD_PKT_BITS-1:0] asm_q, asm_d;
  logic [7:0]                     chk_q, chk_d;
  logic [CW-1:0]                  byte_cnt_q, byte_cnt_d;
  logic                           load_q, load_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic [TW-1:0]                  tmo_inc;
  logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer_q, prog_buffer_d;
  logic                           is_sym_mode_q, is_sym_mode_d;
  logic                           pkt_ok_q, pkt_ok_d;
  logic                           pkt_err_q, pkt_err_d;
  logic                           commit;

`ifdef PROG_RX_FRAME_SYNC_EN
  logic [PROG_PAYLD_PKT_BITS-1:0] pending_buf_q, pending_buf_d;
  logic                           pending_mode_q, pending_mode_d;
  logic                           pending_vld_q, pending_vld_d;
`else
  logic                           frame_start_unused;
  assign frame_start_unused = frame_start;
`endif

  // Packet framing, checksum and idle timeout.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    byte_cnt_d = byte_cnt_q;
    load_d     = load_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    commit     = 1'b0;
    tmo_inc    = tmo_q + TW'(1);
    tmo_d      = (state_q == S_IDLE || rx_valid) ? '0 : tmo_inc;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          if (rx_data == CMD_LOAD) begin
            state_d    = S_PAYLOAD;
            chk_d      = CMD_LOAD;
            byte_cnt_d = '0;
            load_d     = 1'b1;
            asm_d      = '0;
          end else if (rx_data == CMD_NOP) begin
            state_d = S_CHECK;
            chk_d   = CMD_NOP;
            load_d  = 1'b0;
          end else begin
            state_d   = S_IDLE;
            pkt_err_d = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt_q == CW'(i)) asm_d[i*8 +: 8] = rx_data;
          end
          chk_d      = chk_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (byte_cnt_q == LAST_BYTE) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            pkt_ok_d = 1'b1;
            commit   = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the limit cycle keeps the packet alive.
    if (state_q != S_IDLE && !rx_valid && tmo_inc == TMO_LIMIT) begin
      state_d   = S_IDLE;
      pkt_err_d = 1'b1;
      tmo_d     = '0;
      asm_d     = '0;
    end
  end

  // Commit path: immediate, or staged until the frame boundary.
  always_comb begin
    prog_buffer_d = prog_buffer_q;
    is_sym_mode_d = is_sym_mode_q;
`ifdef PROG_RX_FRAME_SYNC_EN
    pending_buf_d  = pending_buf_q;
    pending_mode_d = pending_mode_q;
    pending_vld_d  = pending_vld_q;
    // Apply the old pending values first; a commit on this same edge waits for the next frame.
    if (frame_start && pending_vld_q) begin
      prog_buffer_d = pending_buf_q;
      is_sym_mode_d = pending_mode_q;
      pending_vld_d = 1'b0;
    end
    if (commit) begin
      pending_buf_d  = load_q ? asm_q : (pending_vld_q ? pending_buf_q : prog_buffer_q);
      pending_mode_d = load_q;
      pending_vld_d  = 1'b1;
    end
`else
    if (commit) begin
      if (load_q) prog_buffer_d = asm_q;
      is_sym_mode_d = load_q;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      asm_q          <= '0;
      chk_q          <= '0;
      byte_cnt_q     <= '0;
      load_q         <= 1'b0;
      tmo_q          <= '0;
      prog_buffer_q  <= '0;
      is_sym_mode_q  <= 1'b0;
      pkt_ok_q       <= 1'b0;
      pkt_err_q      <= 1'b0;
`ifdef PROG_RX_FRAME_SYNC_EN
      pending_buf_q  <= '0;
      pending_mode_q <= 1'b0;
      pending_vld_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      asm_q          <= asm_d;
      chk_q          <= chk_d;
      byte_cnt_q     <= byte_cnt_d;
      load_q         <= load_d;
      tmo_q          <= tmo_d;
      prog_buffer_q  <= prog_buffer_d;
      is_sym_mode_q  <= is_sym_mode_d;
      pkt_ok_q       <= pkt_ok_d;
      pkt_err_q      <= pkt_err_d;
`ifdef PROG_RX_FRAME_SYNC_EN
      pending_buf_q  <= pending_buf_d;
      pending_mode_q <= pending_mode_d;
      pending_vld_q  <= pending_vld_d;
`endif
    end
  end

  assign prog_buffer = prog_buffer_q;
  assign is_sym_mode = is_sym_mode_q;
  assign pkt_ok      = pkt_ok_q;
  assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_prog_packet_rx.sv
// Self-checking bench for prog_packet_rx: directed framing/timeout/reset cases plus random packets
// checked against a packet-level model (build with PROG_RX_FRAME_SYNC_EN to exercise deferred commits).
module tb_prog_packet_rx;

  localparam int unsigned PW   = 48;
  localparam int unsigned NB   = PW / 8;
  localparam int unsigned TMO  = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_start;
  logic [PW-1:0] prog_buffer;
  logic          is_sym_mode;
  logic          pkt_ok;
  logic          pkt_err;

  int tests = 0;
  int fails = 0;

  // Packet-level reference state.
  logic [PW-1:0] exp_buf;
  logic          exp_mode;
  logic [PW-1:0] pend_buf;
  logic          pend_mode;
  logic          pend_vld;
  bit            fs_rand;

  always #5 clk = ~clk;

  prog_packet_rx #(
    .PROG_PAYLD_PKT_BITS(PW),
    .SYNC_BYTE          (SYNC),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .prog_buffer(prog_buffer),
    .is_sym_mode(is_sym_mode),
    .pkt_ok     (pkt_ok),
    .pkt_err    (pkt_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_ok, input bit exp_err);
    check({tag, ".pkt_ok"}, 64'(pkt_ok), 64'(exp_ok));
    check({tag, ".pkt_err"}, 64'(pkt_err), 64'(exp_err));
    check({tag, ".prog_buffer"}, 64'(prog_buffer), 64'(exp_buf));
    check({tag, ".is_sym_mode"}, 64'(is_sym_mode), 64'(exp_mode));
  endtask

  // One clock: drive inputs, advance the model at the edge, then check registered outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit exp_ok, input bit exp_err,
                      input bit commit, input bit load, input logic [PW-1:0] pl, input bit fs_force);
    bit fs;
    fs          = fs_force || (fs_rand && ($urandom_range(3) == 0));
    rx_valid    = v;
    rx_data     = v ? d : 8'($urandom);
    frame_start = fs;
    @(posedge clk);
`ifdef PROG_RX_FRAME_SYNC_EN
    if (fs && pend_vld) begin
      exp_buf  = pend_buf;
      exp_mode = pend_mode;
      pend_vld = 1'b0;
    end
    if (commit) begin
      if (load) pend_buf = pl;
      else if (!pend_vld) pend_buf = exp_buf;
      pend_mode = load;
      pend_vld  = 1'b1;
    end
`else
    if (commit) begin
      if (load) exp_buf = pl;
      exp_mode = load;
    end
`endif
    #1;
    rx_valid    = 1'b0;
    frame_start = 1'b0;
    check_outputs(v ? "byte" : "idle", exp_ok, exp_err);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Full packet; the checksum is XOR of command and payload bytes.
  task automatic send_pkt(input bit load, input logic [PW-1:0] pl, input bit corrupt,
                          input int max_gap, input int stall_idx, input int stall_len,
                          input bit fs_last);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    logic [7:0] b;
    bytes = {};
    bytes.push_back(SYNC);
    bytes.push_back(load ? 8'h01 : 8'h00);
    chk = load ? 8'h01 : 8'h00;
    if (load) begin
      for (int i = 0; i < NB; i++) begin
        b = pl[i*8 +: 8];
        bytes.push_back(b);
        chk = chk ^ b;
      end
    end
    if (corrupt) chk = chk ^ (8'h01 << $urandom_range(7));
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i]);
      if (i == stall_idx) gap(stall_len);
      else gap($urandom_range(max_gap));
    end
    step(1'b1, chk, !corrupt, corrupt, !corrupt, load, pl, fs_last);
  endtask

  task automatic model_reset();
    exp_buf  = '0;
    exp_mode = 1'b0;
    pend_buf = '0;
    pend_mode = 1'b0;
    pend_vld = 1'b0;
  endtask

  initial begin
    int         lat;
    bit         seen;
    logic [7:0] bad;
    int         kind;

    fs_rand     = 1'b0;
    rst_n       = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    frame_start = 1'b0;
    model_reset();
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(2);

    // Reference packet: h=32, w=64, r=3, g=5, b=7.
    send_pkt(1'b1, 48'h0753_0040_0020, 1'b0, 0, -1, 0, 1'b0);
    gap(1);
`ifdef PROG_RX_FRAME_SYNC_EN
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
`endif
    check("ref_pkt.buf", 64'(prog_buffer), 64'h0000_0753_0040_0020);
    check("ref_pkt.mode", 64'(is_sym_mode), 64'd1);

    // Bad checksum keeps prior values, then a NOP packet clears symbol mode.
    send_pkt(1'b1, 48'h0753_0040_0020, 1'b1, 2, -1, 0, 1'b0);
    send_pkt(1'b0, '0, 1'b0, 2, -1, 0, 1'b0);
    gap(1);

    // Junk in IDLE is ignored silently.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    // Bad command.
    send_byte(SYNC);
    step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send_pkt(1'b1, 48'h0123_0456_0789, 1'b0, 1, -1, 0, 1'b0);
    // SYNC values inside the payload are plain data.
    send_pkt(1'b1, 48'hA5A5_A5A5_A5A5, 1'b0, 0, -1, 0, 1'b0);

    // Timeout: error 15 cycles after the last byte.
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h20);
    seen = 1'b0;
    lat  = -1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (pkt_err) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("timeout.latency", 64'(lat), 64'd15);
    check("timeout.buf", 64'(prog_buffer), 64'(exp_buf));
    send_pkt(1'b1, 48'h0001_0002_0003, 1'b0, 1, -1, 0, 1'b0);

    // A byte on the limit cycle wins over the timeout.
    send_pkt(1'b1, 48'h0F0F_00AA_0055, 1'b0, 0, 1, TMO - 2, 1'b0);

    // Reset mid-packet, then the tail of the packet must not be accepted.
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h20);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset", 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h53);
    send_byte(8'h07);
    send_byte(8'h35);
    gap(2);

`ifdef PROG_RX_FRAME_SYNC_EN
    // Last pending commit wins; a commit coincident with frame_start waits for the next one.
    send_pkt(1'b1, 48'h0111_0010_0010, 1'b0, 1, -1, 0, 1'b0);
    send_pkt(1'b1, 48'h0222_0020_0010, 1'b0, 1, -1, 0, 1'b0);
    send_pkt(1'b1, 48'h0333_0030_0010, 1'b0, 1, -1, 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("fsync.last_wins", 64'(prog_buffer), 64'h0000_0333_0030_0010);
    send_pkt(1'b1, 48'h0444_0040_0010, 1'b0, 1, -1, 0, 1'b0);
    send_pkt(1'b1, 48'h0555_0050_0010, 1'b0, 1, -1, 0, 1'b1);
    check("fsync.coincident_old", 64'(prog_buffer), 64'h0000_0444_0040_0010);
    gap(1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("fsync.coincident_next", 64'(prog_buffer), 64'h0000_0555_0050_0010);
`endif

    // Randomized packets with random gaps and random frame_start pulses.
    fs_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(9);
      if (kind == 0) begin
        bad = 8'($urandom_range(255, 2));
        send_byte(SYNC);
        step(1'b1, bad, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      end else if (kind == 1) begin
        bad = 8'($urandom);
        if (bad == SYNC) bad = 8'h5A;
        send_byte(bad);
      end else begin
        send_pkt(kind != 2, {16'($urandom), 32'($urandom)}, kind == 3, 3, -1, 0, 1'b0);
      end
      gap($urandom_range(2));
    end
    fs_rand = 1'b0;
    gap(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
